// File: rtl/lag_meter_pkg.sv
// Shared constants and state encoding for the flash-to-sensor lag meter
// and the display formatter that consumes its results.
package lag_meter_pkg;

    localparam int unsigned LAG_WIDTH      = 20;
    localparam int unsigned LAG_TIMEOUT_US = 500000;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MEASURE   = 2'd1,
        WAIT_DARK = 2'd2
    } lm_state_e;

endpackage

// File: rtl/lag_meter_sensor_debounce.sv
// Photo-sensor conditioning: polarity, 2-FF synchronizer and symmetric
// active/inactive run counters that qualify detection and darkness.
module sensor_debounce #(
    parameter int unsigned DEBOUNCE           = 16,
    parameter bit          SENSOR_ACTIVE_HIGH = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic sensor,
    output logic sensor_s,
    output logic run_start,
    output logic det,
    output logic dark
);

    localparam int unsigned     CW      = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE);
    localparam logic [CW-1:0]   CNT_DET = CW'(DEBOUNCE - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic [CW-1:0] act_cnt_q, act_cnt_d;
    logic [CW-1:0] inact_cnt_q, inact_cnt_d;

    always_comb begin
        sync1_d     = SENSOR_ACTIVE_HIGH ? sensor : ~sensor;
        sync2_d     = sync1_q;
        act_cnt_d   = '0;
        inact_cnt_d = '0;
        // Counters saturate so det stays a single pulse while dark stays a level.
        if (sync2_q) begin
            act_cnt_d = (act_cnt_q == CNT_MAX) ? act_cnt_q : act_cnt_q + 1'b1;
        end else begin
            inact_cnt_d = (inact_cnt_q == CNT_MAX) ? inact_cnt_q : inact_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            act_cnt_q   <= '0;
            inact_cnt_q <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            act_cnt_q   <= act_cnt_d;
            inact_cnt_q <= inact_cnt_d;
        end
    end

    assign sensor_s  = sync2_q;
    assign run_start = sync2_q && (act_cnt_q == '0);
    assign det       = sync2_q && (act_cnt_q == CNT_DET);
    assign dark      = !sync2_q && ((inact_cnt_q == CNT_DET) || (inact_cnt_q == CNT_MAX));

endmodule

// File: rtl/lag_meter.sv
// Measures microseconds from the video generator's flash trigger to the
// photo-sensor detecting it, with min/max/count statistics and timeout.
module lag_meter
    import lag_meter_pkg::*;
#(
    parameter int unsigned CLK_PER_US         = 25,
    parameter int unsigned TIMEOUT_US         = LAG_TIMEOUT_US,
    parameter int unsigned DEBOUNCE           = 16,
    parameter bit          SENSOR_ACTIVE_HIGH = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 starttrigger,
    input  logic                 sensor,
    input  logic                 clear_stats,
    output logic [LAG_WIDTH-1:0] lag_us,
    output logic                 lag_valid,
    output logic                 timeout,
    output logic [LAG_WIDTH-1:0] min_us,
    output logic [LAG_WIDTH-1:0] max_us,
    output logic [7:0]           sample_count,
    output logic                 busy
);

    localparam int unsigned            PW        = $clog2(CLK_PER_US);
    localparam logic [PW-1:0]          PRESC_MAX = PW'(CLK_PER_US - 1);
    localparam logic [LAG_WIDTH-1:0]   US_MAX    = LAG_WIDTH'(TIMEOUT_US);

    lm_state_e              state_q, state_d;
    logic [PW-1:0]          presc_q, presc_d;
    logic [LAG_WIDTH-1:0]   us_q, us_d;
    logic [LAG_WIDTH-1:0]   cand_q, cand_d;
    logic [LAG_WIDTH-1:0]   lag_q, lag_d;
    logic [LAG_WIDTH-1:0]   min_q, min_d;
    logic [LAG_WIDTH-1:0]   max_q, max_d;
    logic [7:0]             count_q, count_d;
    logic                   lag_valid_q, lag_valid_d;
    logic                   timeout_q, timeout_d;
    logic                   sample;
    logic [LAG_WIDTH-1:0]   sample_val;
    logic                   sensor_s, run_start, det, dark;

    sensor_debounce #(
        .DEBOUNCE           (DEBOUNCE),
        .SENSOR_ACTIVE_HIGH (SENSOR_ACTIVE_HIGH)
    ) u_debounce (
        .clock     (clock),
        .reset     (reset),
        .sensor    (sensor),
        .sensor_s  (sensor_s),
        .run_start (run_start),
        .det       (det),
        .dark      (dark)
    );

    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        us_d        = us_q;
        cand_d      = cand_q;
        lag_d       = lag_q;
        lag_valid_d = 1'b0;
        timeout_d   = 1'b0;
        sample      = 1'b0;
        // With DEBOUNCE=1 the run starts and is accepted on the same cycle.
        sample_val  = run_start ? us_q : cand_q;

        case (state_q)
            IDLE: begin
                if (starttrigger) begin
                    presc_d = '0;
                    us_d    = '0;
                    cand_d  = '0;
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (presc_q == PRESC_MAX) begin
                    presc_d = '0;
                    if (us_q != US_MAX) begin
                        us_d = us_q + 1'b1;
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
                if (!sensor_s) begin
                    cand_d = '0;
                end else if (run_start) begin
                    cand_d = us_q;
                end
                if (det) begin
                    sample  = 1'b1;
                    state_d = WAIT_DARK;
                end else if (us_q == US_MAX) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            WAIT_DARK: begin
                if (dark) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (clear_stats) begin
            min_d   = '1;
            max_d   = '0;
            count_d = '0;
        end else begin
            min_d   = min_q;
            max_d   = max_q;
            count_d = count_q;
        end
        if (sample) begin
            lag_d       = sample_val;
            lag_valid_d = 1'b1;
            if (sample_val < min_d) begin
                min_d = sample_val;
            end
            if (sample_val > max_d) begin
                max_d = sample_val;
            end
            if (count_d != 8'hFF) begin
                count_d = count_d + 8'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            presc_q     <= '0;
            us_q        <= '0;
            cand_q      <= '0;
            lag_q       <= '0;
            lag_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            min_q       <= '1;
            max_q       <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            us_q        <= us_d;
            cand_q      <= cand_d;
            lag_q       <= lag_d;
            lag_valid_q <= lag_valid_d;
            timeout_q   <= timeout_d;
            min_q       <= min_d;
            max_q       <= max_d;
            count_q     <= count_d;
        end
    end

    assign lag_us       = lag_q;
    assign lag_valid    = lag_valid_q;
    assign timeout      = timeout_q;
    assign min_us       = min_q;
    assign max_us       = max_q;
    assign sample_count = count_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_lag_meter.sv
// Self-checking bench for lag_meter: sensor waveforms per measurement are
// scored against a reference built from the lag/debounce/timeout rules.
module tb_lag_meter;
    import lag_meter_pkg::*;

    localparam int CPU  = 4;
    localparam int D    = 3;
    localparam int T    = 100;
    localparam int MAXC = 512;

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic                 starttrigger = 1'b0;
    logic                 sensor = 1'b0;
    logic                 clear_stats = 1'b0;
    logic [LAG_WIDTH-1:0] lag_us, min_us, max_us;
    logic                 lag_valid, timeout, busy;
    logic [7:0]           sample_count;

    int          checks = 0;
    int          errors = 0;
    int          raw [MAXC];
    int unsigned hist [$];
    int unsigned last_lag = 0;
    bit          in_wait = 1'b0;

    always #5 clock = ~clock;

    lag_meter #(
        .CLK_PER_US         (CPU),
        .TIMEOUT_US         (T),
        .DEBOUNCE           (D),
        .SENSOR_ACTIVE_HIGH (1'b1)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .starttrigger (starttrigger),
        .sensor       (sensor),
        .clear_stats  (clear_stats),
        .lag_us       (lag_us),
        .lag_valid    (lag_valid),
        .timeout      (timeout),
        .min_us       (min_us),
        .max_us       (max_us),
        .sample_count (sample_count),
        .busy         (busy)
    );

    function automatic int unsigned exp_min();
        int unsigned m = 32'hFFFFF;
        foreach (hist[i]) if (hist[i] < m) m = hist[i];
        return m;
    endfunction

    function automatic int unsigned exp_max();
        int unsigned m = 0;
        foreach (hist[i]) if (hist[i] > m) m = hist[i];
        return m;
    endfunction

    function automatic int unsigned exp_cnt();
        return (hist.size() > 255) ? 255 : hist.size();
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_raw(input int sustain_from);
        for (int i = 0; i < MAXC; i++) raw[i] = (sustain_from >= 0 && i >= sustain_from) ? 1 : 0;
    endtask

    task automatic add_glitch(input int s, input int len);
        for (int i = s; i < s + len; i++) raw[i] = 1;
    endtask

    // Trigger, drive raw[] cycle by cycle, and score the resulting pulse and stats.
    task automatic run_measure(input bit clr_on_det);
        int          ev = T * CPU + 1;
        bit          det = 1'b0;
        int unsigned lag = 0;
        int          run = 0;
        for (int c = 0; c <= T * CPU; c++) begin
            int synced = (c >= 2) ? raw[c - 2] : 0;
            run = (synced != 0) ? run + 1 : 0;
            if (run == D) begin
                det = 1'b1;
                lag = int'(unsigned'(c - D + 1) / CPU);
                if (lag > T) lag = T;
                ev = c + 1;
                break;
            end
        end
        starttrigger = 1'b1;
        step();
        starttrigger = 1'b0;
        for (int c = 0; c <= ev; c++) begin
            sensor      = (raw[c] != 0);
            clear_stats = clr_on_det && (c == ev - 1);
            checks++;
            if (lag_valid !== (c == ev && det)) begin
                errors++;
                $display("FAIL lag_valid c=%0d: got %b want %b", c, lag_valid, (c == ev && det));
            end
            checks++;
            if (timeout !== (c == ev && !det)) begin
                errors++;
                $display("FAIL timeout c=%0d: got %b want %b", c, timeout, (c == ev && !det));
            end
            checks++;
            if (busy !== ((c < ev) || det)) begin
                errors++;
                $display("FAIL busy c=%0d: got %b want %b", c, busy, ((c < ev) || det));
            end
            if (c < ev) step();
        end
        clear_stats = 1'b0;
        if (clr_on_det) hist.delete();
        if (det) begin
            hist.push_back(lag);
            last_lag = lag;
        end
        in_wait = det;
        checks++;
        if (lag_us !== LAG_WIDTH'(last_lag)) begin
            errors++;
            $display("FAIL lag_us: got %0d want %0d", lag_us, last_lag);
        end
        checks++;
        if (min_us !== LAG_WIDTH'(exp_min())) begin
            errors++;
            $display("FAIL min_us: got %0d want %0d", min_us, exp_min());
        end
        checks++;
        if (max_us !== LAG_WIDTH'(exp_max())) begin
            errors++;
            $display("FAIL max_us: got %0d want %0d", max_us, exp_max());
        end
        checks++;
        if (sample_count !== 8'(exp_cnt())) begin
            errors++;
            $display("FAIL sample_count: got %0d want %0d", sample_count, exp_cnt());
        end
    endtask

    task automatic go_dark();
        sensor = 1'b0;
        for (int j = 1; j <= D + 2; j++) begin
            step();
            if (in_wait && j >= D + 1) begin
                checks++;
                if (busy !== (j == D + 1)) begin
                    errors++;
                    $display("FAIL dark_exit j=%0d: got busy %b want %b", j, busy, (j == D + 1));
                end
            end
        end
        in_wait = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        checks++;
        if ({lag_us, lag_valid, timeout, busy, max_us, sample_count} !== '0 || min_us !== 20'hFFFFF) begin
            errors++;
            $display("FAIL reset_state: got lag=%0d v=%b t=%b b=%b min=%h max=%0d cnt=%0d want 0 0 0 0 fffff 0 0",
                     lag_us, lag_valid, timeout, busy, min_us, max_us, sample_count);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic();
        set_raw(149);
        run_measure(1'b0);
        checks++;
        if (lag_us !== 20'd37 || sample_count !== 8'd1) begin
            errors++;
            $display("FAIL basic_37: got lag=%0d cnt=%0d want 37 1", lag_us, sample_count);
        end
        go_dark();
    endtask

    task automatic test_glitch();
        set_raw(198);
        add_glitch(38, 2);
        run_measure(1'b0);
        checks++;
        if (lag_us !== 20'd50) begin
            errors++;
            $display("FAIL glitch_50: got %0d want 50", lag_us);
        end
        go_dark();
    endtask

    task automatic test_timeout();
        set_raw(-1);
        run_measure(1'b0);
        checks++;
        if (lag_us !== 20'd50 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_hold: got lag=%0d busy=%b want 50 0", lag_us, busy);
        end
        go_dark();
        set_raw(396);
        run_measure(1'b0);
        checks++;
        if (lag_us !== 20'd99) begin
            errors++;
            $display("FAIL det_at_limit: got %0d want 99", lag_us);
        end
        go_dark();
        set_raw(397);
        run_measure(1'b0);
        go_dark();
    endtask

    task automatic test_stats();
        clear_stats = 1'b1;
        step();
        clear_stats = 1'b0;
        hist.delete();
        checks++;
        if (min_us !== 20'hFFFFF || max_us !== '0 || sample_count !== '0) begin
            errors++;
            $display("FAIL clear1: got min=%h max=%0d cnt=%0d want fffff 0 0", min_us, max_us, sample_count);
        end
        set_raw(118); run_measure(1'b0); go_dark();
        set_raw(38);  run_measure(1'b0); go_dark();
        set_raw(78);  run_measure(1'b0); go_dark();
        checks++;
        if (min_us !== 20'd10 || max_us !== 20'd30 || sample_count !== 8'd3) begin
            errors++;
            $display("FAIL stats3: got min=%0d max=%0d cnt=%0d want 10 30 3", min_us, max_us, sample_count);
        end
        clear_stats = 1'b1;
        step();
        clear_stats = 1'b0;
        hist.delete();
        checks++;
        if (min_us !== 20'hFFFFF || max_us !== '0 || sample_count !== '0 || lag_us !== 20'd20) begin
            errors++;
            $display("FAIL clear2: got min=%h max=%0d cnt=%0d lag=%0d want fffff 0 0 20",
                     min_us, max_us, sample_count, lag_us);
        end
    endtask

    task automatic test_stuck_bright();
        set_raw(60);
        run_measure(1'b0);
        for (int i = 0; i < 20; i++) begin
            starttrigger = (i % 5 == 0);
            step();
            checks++;
            if (busy !== 1'b1 || lag_valid !== 1'b0 || timeout !== 1'b0) begin
                errors++;
                $display("FAIL stuck i=%0d: got busy=%b v=%b t=%b want 1 0 0", i, busy, lag_valid, timeout);
            end
        end
        starttrigger = 1'b0;
        go_dark();
        set_raw(100);
        run_measure(1'b0);
        checks++;
        if (lag_us !== 20'd25) begin
            errors++;
            $display("FAIL after_stuck: got %0d want 25", lag_us);
        end
        go_dark();
    endtask

    task automatic test_clear_coincide();
        set_raw(80);
        run_measure(1'b1);
        checks++;
        if (sample_count !== 8'd1 || min_us !== 20'd20 || max_us !== 20'd20) begin
            errors++;
            $display("FAIL clear_coincide: got cnt=%0d min=%0d max=%0d want 1 20 20", sample_count, min_us, max_us);
        end
        go_dark();
    endtask

    task automatic test_reset_mid();
        starttrigger = 1'b1;
        step();
        starttrigger = 1'b0;
        repeat (160) step();
        reset = 1'b1;
        step();
        hist.delete();
        last_lag = 0;
        in_wait  = 1'b0;
        checks++;
        if ({lag_us, lag_valid, timeout, busy, max_us, sample_count} !== '0 || min_us !== 20'hFFFFF) begin
            errors++;
            $display("FAIL reset_mid: got lag=%0d v=%b t=%b b=%b min=%h max=%0d cnt=%0d want 0 0 0 0 fffff 0 0",
                     lag_us, lag_valid, timeout, busy, min_us, max_us, sample_count);
        end
        reset = 1'b0;
        step();
        set_raw(46);
        run_measure(1'b0);
        checks++;
        if (lag_us !== 20'd12) begin
            errors++;
            $display("FAIL reset_then_12: got %0d want 12", lag_us);
        end
        go_dark();
    endtask

    task automatic test_random();
        for (int n = 0; n < 10; n++) begin
            int sustain = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(2, 400));
            int limit   = (sustain < 0) ? 400 : sustain;
            int pos     = int'($urandom_range(2, 30));
            set_raw(sustain);
            while (pos + D < limit) begin
                int len = int'($urandom_range(1, D - 1));
                add_glitch(pos, len);
                pos += len + int'($urandom_range(1, 40));
            end
            run_measure($urandom_range(0, 3) == 0);
            go_dark();
        end
    endtask

    task automatic test_saturate();
        for (int n = 0; n < 258; n++) begin
            set_raw(int'($urandom_range(0, 20)));
            run_measure(1'b0);
            go_dark();
        end
        checks++;
        if (sample_count !== 8'd255) begin
            errors++;
            $display("FAIL count_saturate: got %0d want 255", sample_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_timeout();
        test_stats();
        test_stuck_bright();
        test_clear_coincide();
        test_reset_mid();
        test_random();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
